// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the reset_seq multi-domain reset release sequencer.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ASSERT   = 3'd1,
    ST_ACK_WAIT = 3'd2,
    ST_HOLD     = 3'd3,
    ST_DONE     = 3'd4,
    ST_FAULT    = 3'd5
  } state_t;

  // The counter must hold the larger of the two intervals without wrapping.
  function automatic int cnt_width(input int delay, input int timeout);
    int m;
    m = (delay > timeout) ? delay : timeout;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/reset_seq_sync_2ff.sv
// Single-bit two-flop synchronizer for the asynchronous rdy acknowledgements.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/reset_seq.sv
// Sequenced reset release for STAGES domains with per-stage ack timeout and fault report.
// Optional macro RESET_SEQ_RELOCK_EN: loss of any ack in DONE reruns the whole sequence.
module reset_seq
  import reset_seq_pkg::*;
#(
  parameter int STAGES      = 4,
  parameter int STAGE_DELAY = 1000,
  parameter int TIMEOUT     = 100000
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_req,
  input  logic [STAGES-1:0]         i_rdy,
  output logic [STAGES-1:0]         o_rst_out,
  output logic                      o_done,
  output logic                      o_fault,
  output logic [$clog2(STAGES)-1:0] o_fault_stage,
  output state_t                    o_state
);

  localparam int KW = $clog2(STAGES);
  localparam int CW = cnt_width(STAGE_DELAY, TIMEOUT);
  localparam logic [CW-1:0] DLY_LAST = CW'(STAGE_DELAY - 1);
  localparam logic [CW-1:0] TO_LIM   = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [KW-1:0] K_LAST   = KW'(STAGES - 1);

  // Handshake: i_req is a level (1 = run / stay released, 0 = abort now); each
  // rdy bit is a level ack sampled only while its own stage k is awaited.
  logic [STAGES-1:0] w_rdy_s;

  for (genvar g = 0; g < STAGES; g++) begin : g_sync
    sync_2ff u_sync (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_d   (i_rdy[g]),
      .o_q   (w_rdy_s[g])
    );
  end

  state_t            r_state;
  state_t            w_state_nxt;
  logic [KW-1:0]     r_k;
  logic [KW-1:0]     w_k_nxt;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt_nxt;
  logic [STAGES-1:0] r_rst_out;
  logic [STAGES-1:0] w_rst_nxt;
  logic              r_done;
  logic              w_done_nxt;
  logic              r_fault;
  logic              w_fault_nxt;
  logic [KW-1:0]     r_fault_stage;
  logic [KW-1:0]     w_fault_stage_nxt;

  always_comb begin
    w_state_nxt       = r_state;
    w_k_nxt           = r_k;
    w_cnt_nxt         = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CW'(1);
    w_rst_nxt         = '1;
    w_done_nxt        = 1'b0;
    w_fault_nxt       = 1'b0;
    w_fault_stage_nxt = '0;

    case (r_state)
      ST_IDLE: begin
        w_k_nxt   = '0;
        w_cnt_nxt = '0;
        if (i_req) w_state_nxt = ST_ASSERT;
      end
      ST_ASSERT: begin
        if (r_cnt == DLY_LAST) begin
          w_state_nxt = ST_ACK_WAIT;
          w_k_nxt     = '0;
          w_cnt_nxt   = '0;
        end
      end
      ST_ACK_WAIT: begin
        // An ack arriving on the timeout cycle still counts as success.
        if (w_rdy_s[r_k]) begin
          w_state_nxt = (r_k == K_LAST) ? ST_DONE : ST_HOLD;
          w_cnt_nxt   = '0;
        end else if (r_cnt == TO_LIM) begin
          w_state_nxt = ST_FAULT;
        end
      end
      ST_HOLD: begin
        if (r_cnt == DLY_LAST) begin
          w_state_nxt = ST_ACK_WAIT;
          w_k_nxt     = r_k + KW'(1);
          w_cnt_nxt   = '0;
        end
      end
      ST_DONE: begin
        w_cnt_nxt = '0;
`ifdef RESET_SEQ_RELOCK_EN
        if (!(&w_rdy_s)) begin
          w_state_nxt = ST_ASSERT;
          w_k_nxt     = '0;
        end
`endif
      end
      ST_FAULT: begin
        w_cnt_nxt = '0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (!i_req && (r_state != ST_IDLE)) begin
      w_state_nxt = ST_IDLE;
      w_k_nxt     = '0;
      w_cnt_nxt   = '0;
    end

    // Outputs are decoded from the next state so they register glitch-free.
    case (w_state_nxt)
      ST_ACK_WAIT, ST_HOLD: begin
        for (int i = 0; i < STAGES; i++) w_rst_nxt[i] = (KW'(i) > w_k_nxt);
      end
      ST_FAULT: begin
        for (int i = 0; i < STAGES; i++) w_rst_nxt[i] = (KW'(i) >= w_k_nxt);
        w_fault_nxt       = 1'b1;
        w_fault_stage_nxt = w_k_nxt;
      end
      ST_DONE: begin
        w_rst_nxt  = '0;
        w_done_nxt = 1'b1;
      end
      default: begin
        w_rst_nxt = '1;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_k           <= '0;
      r_cnt         <= '0;
      r_rst_out     <= '1;
      r_done        <= 1'b0;
      r_fault       <= 1'b0;
      r_fault_stage <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_k           <= w_k_nxt;
      r_cnt         <= w_cnt_nxt;
      r_rst_out     <= w_rst_nxt;
      r_done        <= w_done_nxt;
      r_fault       <= w_fault_nxt;
      r_fault_stage <= w_fault_stage_nxt;
    end
  end

  assign o_rst_out     = r_rst_out;
  assign o_done        = r_done;
  assign o_fault       = r_fault;
  assign o_fault_stage = r_fault_stage;
  assign o_state       = r_state;

endmodule
